// File: rtl/aes_enc_round_ctrl.sv
// aes_enc_round_ctrl: iterative AES encryption round controller.
// One 128-bit state register, one round per accepted round key. Round keys are
// fetched from an external key store with a registered rk_req/rk_idx request
// and an rk_valid qualifier. SubBytes, ShiftRows and MixColumns are each built
// once and shared by every round; the final round taps the ShiftRows output.
// Optional feature: define AES_ENC_ABORT_EN to add the 'abort' input.
module aes_enc_round_ctrl #(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [127:0]   plaintext,
  output logic           rk_req,
  output logic [RKW-1:0] rk_idx,
  input  logic           rk_valid,
  input  logic [127:0]   rk,
`ifdef AES_ENC_ABORT_EN
  input  logic           abort,
`endif
  output logic           busy,
  output logic           done,
  output logic [127:0]   ciphertext
);

  if (NR < 1 || NR > (2 ** RKW) - 1) begin : g_bad_nr
    $error("aes_enc_round_ctrl: NR must be in 1..2**RKW-1");
  end

  typedef enum logic [2:0] {IDLE, KEY0, ROUND, FINAL, DONE} state_e;

  state_e         state_q, state_d;
  logic [RKW-1:0] cnt_q, cnt_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   ct_q, ct_d;
  logic           rk_req_q, rk_req_d;
  logic [RKW-1:0] rk_idx_q, rk_idx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [127:0]   sb_out, sr_out, mc_out;

  // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xt(x);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254, which maps 0 to 0) plus affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    inv = 8'h01;
    p   = x;
    for (int unsigned i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned b = 0; b < 16; b++) o[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
    return o;
  endfunction

  // Byte 4c+r is row r of column c; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  // Shared round datapath: one instance of each transform
  always_comb begin
    sb_out = sub_bytes(st_q);
    sr_out = shift_rows(sb_out);
    mc_out = mix_columns(sr_out);
  end

  // Next-state, datapath and registered-output decode.
  // The plaintext is parked in the state register while waiting for key 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = plaintext;
          cnt_d   = '0;
          state_d = KEY0;
        end
      end
      KEY0: begin
        if (rk_valid) begin
          st_d    = st_q ^ rk;
          cnt_d   = RKW'(1);
          state_d = (NR == 1) ? FINAL : ROUND;
        end
      end
      ROUND: begin
        if (rk_valid) begin
          st_d  = mc_out ^ rk;
          cnt_d = cnt_q + RKW'(1);
          if (cnt_q == RKW'(NR - 1)) state_d = FINAL;
        end
      end
      FINAL: begin
        if (rk_valid) begin
          ct_d    = sr_out ^ rk;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AES_ENC_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      st_d    = st_q;
      ct_d    = ct_q;
    end
`endif
    // Outputs are decoded from the next state so they come straight off flops
    rk_req_d = (state_d == KEY0) || (state_d == ROUND) || (state_d == FINAL);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    case (state_d)
      ROUND:   rk_idx_d = cnt_d;
      FINAL:   rk_idx_d = RKW'(NR);
      default: rk_idx_d = '0;
    endcase
  end

  // State and output registers, asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      st_q     <= '0;
      ct_q     <= '0;
      rk_req_q <= 1'b0;
      rk_idx_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      ct_q     <= ct_d;
      rk_req_q <= rk_req_d;
      rk_idx_q <= rk_idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rk_req     = rk_req_q;
  assign rk_idx     = rk_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Directed testbench for aes_enc_round_ctrl (NR=10) using FIPS-197 C.1 and an
// all-zero boundary vector; the key store is a table indexed by rk_idx.
module tb_aes_enc_round_ctrl;

  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = {16{8'h36}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] plaintext = '0;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid = 1'b0;
  logic [127:0] rk;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;
`ifdef AES_ENC_ABORT_EN
  logic         abort = 1'b0;
`endif

  logic [127:0] rk_tab [16];
  logic         zero_keys = 1'b0;
  logic [127:0] last_ct = '0;
  int           vecs = 0;
  int           errs = 0;

  aes_enc_round_ctrl #(.NR(10), .RKW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk         (rk),
`ifdef AES_ENC_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  always_comb rk = zero_keys ? '0 : rk_tab[rk_idx];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag, input logic [127:0] exp_ct);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_rk_req"}, 128'(rk_req), 128'(0));
    chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
    chk({tag, "_ct"}, ciphertext, exp_ct);
  endtask

  // Starts a block and serves keys until done; exp_lat < 0 skips the latency check.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp_ct,
                           input bit stall, input bit pulse, input int exp_lat);
    int  cyc;
    int  keys;
    bit  got_done;
    plaintext = pt;
    start = 1'b1;
    step();
    start = 1'b0;
    plaintext = ~pt;
    cyc = 1;
    keys = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 300) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        start = pulse && (cyc == 3 || cyc == 7);
        rk_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rk_req) begin
          chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(keys));
          if (rk_valid) keys++;
        end
        step();
        cyc++;
      end
    end
    start = 1'b0;
    rk_valid = 1'b0;
    chk({tag, "_done_seen"}, 128'(got_done), 128'(1));
    if (exp_lat >= 0) chk({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
    chk({tag, "_keys"}, 128'(keys), 128'(11));
    chk({tag, "_busy_at_done"}, 128'(busy), 128'(1));
    chk({tag, "_req_at_done"}, 128'(rk_req), 128'(0));
    chk({tag, "_ct"}, ciphertext, exp_ct);
    last_ct = exp_ct;
    step();
    chk({tag, "_done_pulse"}, 128'(done), 128'(0));
    chk({tag, "_ct_hold"}, ciphertext, exp_ct);
  endtask

  task automatic no_done_for(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (done) seen++;
      step();
    end
    chk({tag, "_no_done"}, 128'(seen), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rk_tab[i] = '0;
    rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    // Reset state
    #12;
    chk_idle_zero("reset", '0);
    rst = 1'b0;
    step();
    chk_idle_zero("post_reset", '0);

    // FIPS-197 C.1, keys always valid, done at cycle 12
    run_block("c1", PT_C1, CT_C1, 1'b0, 1'b0, 12);

    // Same vector with random key stalls
    run_block("c1_stall", PT_C1, CT_C1, 1'b1, 1'b0, -1);

    // Start pulses mid-run are ignored, then a back-to-back all-zero block
    run_block("c1_pulse", PT_C1, CT_C1, 1'b0, 1'b1, 12);
    zero_keys = 1'b1;
    run_block("zero_b2b", '0, CT_Z, 1'b0, 1'b0, 12);
    zero_keys = 1'b0;
    chk("zero_b2b_idle_busy", 128'(busy), 128'(0));

    // Asynchronous reset while round key 5 is being requested
    plaintext = PT_C1;
    start = 1'b1;
    step();
    start = 1'b0;
    rk_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_idx", 128'(rk_idx), 128'(5));
    chk("pre_rst_busy", 128'(busy), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk_idle_zero("async_rst", '0);
    last_ct = '0;
    #2;
    rst = 1'b0;
    step();
    no_done_for("after_rst", 16);
    rk_valid = 1'b0;
    chk_idle_zero("after_rst_idle", '0);
    run_block("c1_after_rst", PT_C1, CT_C1, 1'b0, 1'b0, 12);

`ifdef AES_ENC_ABORT_EN
    // Abort together with rk_valid while round key 4 is requested
    zero_keys = 1'b1;
    plaintext = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    rk_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("pre_abort_idx", 128'(rk_idx), 128'(4));
    abort = 1'b1;
    step();
    abort = 1'b0;
    rk_valid = 1'b0;
    chk_idle_zero("abort", last_ct);
    no_done_for("after_abort", 16);
    chk("after_abort_ct", ciphertext, last_ct);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_in_idle_busy", 128'(busy), 128'(0));
    zero_keys = 1'b0;
    run_block("c1_after_abort", PT_C1, CT_C1, 1'b0, 1'b0, 12);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
